uart_tx_fifo_reader: RTL and testbench

- Transmit-side consumer of the 256x8 UART FIFO. It pops bytes with an active-low read strobe and serialises each byte onto TX as start, data, optional parity and stop bits.
- It sits between the TX FIFO and the pad inside the CoreUARTapb instance.
- Bit timing comes from the shared 16x baud-enable tick. Bytes are sent back-to-back while the FIFO is non-empty.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_tx_fifo_reader.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: transmitter state encoding, oversampling default and parity modes.
package uart_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_POP       = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_DATA = 3'd2;
  localparam logic [STATE_W-1:0] ST_START     = 3'd3;
  localparam logic [STATE_W-1:0] ST_DATA      = 3'd4;
  localparam logic [STATE_W-1:0] ST_PARITY    = 3'd5;
  localparam logic [STATE_W-1:0] ST_STOP      = 3'd6;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter; pulses o_bit_end_c on the baud tick that closes a serial bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_srst,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_bit_end_c
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_end_c = i_tick & ~i_clear & (r_cnt == CNT_LAST);

  // Clear holds the counter at zero so the next bit starts on a fresh count.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_cnt <= '0;
    end else if (i_srst || i_clear) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from the TX FIFO and serialises them as
// start, 7/8 data bits, optional parity and stop bit, back-to-back while data remains.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter bit          SYNC_RESET   = 1'b0,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BAUD_CLOCK,
  input  logic       BIT8,
  input  logic       PARITY_EN,
  input  logic       ODD_N_EVEN,
  input  logic       FIFO_EMPTY,
  input  logic [7:0] FIFO_DATA,
  output logic       FIFO_RDB,
  output logic       TX,
  output logic       TX_BUSY,
  output logic       TXRDY
);

  localparam int unsigned LAT_W = 2;
  localparam int unsigned BIT_W = 3;

  logic [STATE_W-1:0] r_state;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_parity;
  logic               r_bit8;
  logic               r_par_en;
  logic               r_tx;
  logic               r_rdb;
  logic               r_busy;
  logic               r_txrdy;

  logic [STATE_W-1:0] w_state_nxt;
  logic [LAT_W-1:0]   w_lat_cnt_nxt;
  logic [BIT_W-1:0]   w_bit_cnt_nxt;
  logic [7:0]         w_shift_nxt;
  logic               w_parity_nxt;
  logic               w_bit8_nxt;
  logic               w_par_en_nxt;
  logic               w_tx_nxt;
  logic               w_rdb_nxt;
  logic               w_busy_nxt;
  logic               w_timer_clr;
  logic               w_bit_end;
  logic [BIT_W-1:0]   w_last_bit;
  logic               w_arst_n;
  logic               w_srst;

  // SYNC_RESET selects whether RESET_N clears through the async pin or on the clock edge.
  assign w_arst_n = SYNC_RESET ? 1'b1 : RESET_N;
  assign w_srst   = SYNC_RESET & ~RESET_N;

  assign w_timer_clr = (r_state == ST_IDLE) || (r_state == ST_POP) ||
                       (r_state == ST_WAIT_DATA);
  assign w_last_bit  = r_bit8 ? BIT_W'(7) : BIT_W'(6);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .i_clk       (CLK),
    .i_arst_n    (w_arst_n),
    .i_srst      (w_srst),
    .i_clear     (w_timer_clr),
    .i_tick      (BAUD_CLOCK),
    .o_bit_end_c (w_bit_end)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_bit8_nxt    = r_bit8;
    w_par_en_nxt  = r_par_en;
    w_tx_nxt      = r_tx;
    w_rdb_nxt     = 1'b1;
    w_busy_nxt    = r_busy;

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!FIFO_EMPTY) begin
          w_state_nxt = ST_POP;
          w_rdb_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_POP: begin
        w_state_nxt   = ST_WAIT_DATA;
        w_lat_cnt_nxt = '0;
      end
      ST_WAIT_DATA: begin
        if (r_lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
          w_shift_nxt  = FIFO_DATA;
          w_parity_nxt = (^{BIT8 & FIFO_DATA[7], FIFO_DATA[6:0]}) ^ ODD_N_EVEN;
          w_bit8_nxt   = BIT8;
          w_par_en_nxt = PARITY_EN;
          w_state_nxt  = ST_START;
          w_tx_nxt     = 1'b0;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt   = ST_DATA;
          w_bit_cnt_nxt = '0;
          w_tx_nxt      = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == w_last_bit) begin
            w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
            w_tx_nxt    = r_par_en ? r_parity : 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
            w_tx_nxt      = r_shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (!FIFO_EMPTY) begin
            w_state_nxt = ST_POP;
            w_rdb_nxt   = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge w_arst_n) begin
    if (!w_arst_n) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit8    <= 1'b0;
      r_par_en  <= 1'b0;
      r_tx      <= 1'b1;
      r_rdb     <= 1'b1;
      r_busy    <= 1'b0;
      r_txrdy   <= 1'b0;
    end else if (w_srst) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit8    <= 1'b0;
      r_par_en  <= 1'b0;
      r_tx      <= 1'b1;
      r_rdb     <= 1'b1;
      r_busy    <= 1'b0;
      r_txrdy   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_bit8    <= w_bit8_nxt;
      r_par_en  <= w_par_en_nxt;
      r_tx      <= w_tx_nxt;
      r_rdb     <= w_rdb_nxt;
      r_busy    <= w_busy_nxt;
      r_txrdy   <= ~FIFO_EMPTY;
    end
  end

  assign FIFO_RDB = r_rdb;
  assign TX       = r_tx;
  assign TX_BUSY  = r_busy;
  assign TXRDY    = r_txrdy;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader with a small FIFO model of read latency 2.
module tb_uart_tx_fifo_reader;

  logic       CLK;
  logic       RESET_N;
  logic       BAUD_CLOCK;
  logic       BIT8;
  logic       PARITY_EN;
  logic       ODD_N_EVEN;
  logic       FIFO_EMPTY;
  logic [7:0] FIFO_DATA;
  logic       FIFO_RDB;
  logic       TX;
  logic       TX_BUSY;
  logic       TXRDY;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         n_pops   = 0;
  int         baud_div = 1;
  int         baud_cnt = 0;
  logic [7:0] fifo_q[$];
  logic       pend_valid = 1'b0;
  logic [7:0] pend_data  = 8'h00;

  uart_tx_fifo_reader dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .BAUD_CLOCK (BAUD_CLOCK),
    .BIT8       (BIT8),
    .PARITY_EN  (PARITY_EN),
    .ODD_N_EVEN (ODD_N_EVEN),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_DATA  (FIFO_DATA),
    .FIFO_RDB   (FIFO_RDB),
    .TX         (TX),
    .TX_BUSY    (TX_BUSY),
    .TXRDY      (TXRDY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; FIFO pops on an RDB-low edge, data valid one clock later.
  task automatic step();
    logic rdb_pre;
    rdb_pre = FIFO_RDB;
    @(posedge CLK);
    #1;
    baud_cnt   = (baud_cnt + 1) % baud_div;
    BAUD_CLOCK = (baud_cnt == 0);
    if (pend_valid) begin
      FIFO_DATA  = pend_data;
      pend_valid = 1'b0;
    end
    if (rdb_pre === 1'b0) begin
      n_pops++;
      n_assert++;
      assert (fifo_q.size() != 0) else begin
        n_fail++;
        $error("FAIL rdb_when_empty: observed pop with size %0d expected size > 0", fifo_q.size());
      end
      if (fifo_q.size() != 0) pend_data = fifo_q.pop_front();
      pend_valid = 1'b1;
      FIFO_DATA  = 8'h3C;
      FIFO_EMPTY = (fifo_q.size() == 0);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    FIFO_EMPTY = 1'b0;
  endtask

  // Check one frame; bit boundaries are found by counting 16 baud pulses per bit.
  task automatic check_frame(input string tag, input logic [11:0] exp, input int nbits,
                             input int bitlen, input int tog);
    int wait_cnt;
    int pulses;
    int cyc;
    int bad;
    wait_cnt = 0;
    while (TX !== 1'b0 && wait_cnt < 2000) begin
      step();
      wait_cnt++;
    end
    chk($sformatf("%s_start", tag), 32'(TX), 32'(0));
    chk($sformatf("%s_busy", tag), 32'(TX_BUSY), 32'(1));
    for (int i = 0; i < nbits; i++) begin
      if (i == tog) BIT8 = ~BIT8;
      pulses = 0;
      cyc    = 0;
      bad    = 0;
      while (pulses < 16 && cyc < 200) begin
        if (TX !== exp[i]) bad++;
        if (BAUD_CLOCK) pulses++;
        cyc++;
        step();
      end
      chk($sformatf("%s_bit%0d_level", tag, i), bad, 0);
      if (i > 0 || bitlen == 16) chk($sformatf("%s_bit%0d_len", tag, i), cyc, bitlen);
    end
  endtask

  task automatic check_gap(input string tag, input int exp);
    int cnt;
    cnt = 0;
    while (TX === 1'b1 && cnt < 20) begin
      cnt++;
      step();
    end
    chk(tag, cnt, exp);
  endtask

  initial begin
    int p0;
    int lows;
    int wait_cnt;
    CLK        = 1'b0;
    RESET_N    = 1'b0;
    BAUD_CLOCK = 1'b1;
    BIT8       = 1'b1;
    PARITY_EN  = 1'b0;
    ODD_N_EVEN = 1'b0;
    FIFO_EMPTY = 1'b1;
    FIFO_DATA  = 8'h00;
    #12;
    chk("rst_tx", 32'(TX), 32'(1));
    chk("rst_rdb", 32'(FIFO_RDB), 32'(1));
    chk("rst_busy", 32'(TX_BUSY), 32'(0));
    chk("rst_txrdy", 32'(TXRDY), 32'(0));
    step();
    step();
    RESET_N = 1'b1;

    // Empty FIFO: line stays idle, nothing is popped.
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (TX !== 1'b1) lows++;
      step();
    end
    chk("idle_tx_lows", lows, 0);
    chk("idle_pops", n_pops, 0);
    chk("idle_txrdy", 32'(TXRDY), 32'(0));
    chk("idle_busy", 32'(TX_BUSY), 32'(0));

    // 0xA5, 8 data bits, no parity.
    push_byte(8'hA5);
    check_frame("a5", 12'({1'b1, 8'hA5, 1'b0}), 10, 16, -1);
    chk("a5_busy_end", 32'(TX_BUSY), 32'(0));
    chk("a5_pops", n_pops, 1);
    chk("a5_txrdy", 32'(TXRDY), 32'(0));

    // 7 data bits with parity; bit 7 of 0xC1 must not affect parity.
    BIT8 = 1'b0; PARITY_EN = 1'b1; ODD_N_EVEN = 1'b1;
    push_byte(8'h41);
    check_frame("p41_odd", 12'({1'b1, 1'b1, 7'h41, 1'b0}), 10, 16, -1);
    chk("p41_busy_end", 32'(TX_BUSY), 32'(0));
    ODD_N_EVEN = 1'b0;
    push_byte(8'hC1);
    check_frame("pc1_even", 12'({1'b1, 1'b0, 7'h41, 1'b0}), 10, 16, -1);
    BIT8 = 1'b1;
    push_byte(8'h07);
    check_frame("p07_even", 12'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 16, -1);
    PARITY_EN = 1'b0;

    // Three bytes back-to-back: gap is POP plus two latency clocks.
    p0 = n_pops;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    check_frame("b00", 12'({1'b1, 8'h00, 1'b0}), 10, 16, -1);
    chk("b00_txrdy", 32'(TXRDY), 32'(1));
    chk("b00_rdb_pop", 32'(FIFO_RDB), 32'(0));
    check_gap("gap1", 3);
    check_frame("bff", 12'({1'b1, 8'hFF, 1'b0}), 10, 16, -1);
    check_gap("gap2", 3);
    check_frame("b55", 12'({1'b1, 8'h55, 1'b0}), 10, 16, -1);
    chk("b3_pops", n_pops - p0, 3);
    chk("b3_txrdy", 32'(TXRDY), 32'(0));
    chk("b3_busy", 32'(TX_BUSY), 32'(0));

    // Reset during data bit 3 of 0x30 (bit 3 is 0).
    push_byte(8'h30);
    wait_cnt = 0;
    while (TX !== 1'b0 && wait_cnt < 200) begin
      step();
      wait_cnt++;
    end
    for (int i = 0; i < 72; i++) step();
    chk("rst_mid_tx_before", 32'(TX), 32'(0));
    RESET_N = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(TX), 32'(1));
    chk("rst_mid_busy", 32'(TX_BUSY), 32'(0));
    chk("rst_mid_rdb", 32'(FIFO_RDB), 32'(1));
    step();
    step();
    RESET_N = 1'b1;
    p0   = n_pops;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (TX !== 1'b1) lows++;
      step();
    end
    chk("rst_after_tx_lows", lows, 0);
    chk("rst_after_pops", n_pops - p0, 0);
    chk("rst_after_busy", 32'(TX_BUSY), 32'(0));

    // Slow baud (1 pulse per 5 CLKs); BIT8 flips mid-frame, width stays 8.
    baud_div = 5;
    BIT8     = 1'b1;
    push_byte(8'h96);
    check_frame("slow96", 12'({1'b1, 8'h96, 1'b0}), 10, 80, 3);
    chk("slow_busy_end", 32'(TX_BUSY), 32'(0));
    BIT8 = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
